mtm_alu_frame_ctrl: RTL and testbench



---
 rtl/mtm_alu_pkg.sv | 27 ++
 rtl/mtm_alu_crc4_step.sv | 33 +++
 rtl/mtm_alu_frame_ctrl.sv | 118 +++++++++++
 tb/tb_mtm_alu_frame_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU frame path: opcodes, error bit positions,
// frame controller states and the CRC-4 polynomial.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    // x^4 + x + 1, x^4 term implicit
    localparam logic [3:0] CRC4_POLY = 4'b0011;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_HOLD    = 2'd2
    } frame_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mtm_alu_crc4_step.sv
// One combinational CRC-4 update, MSB first, over either a full byte or the
// low nibble of data (bits8 = 0) for the trailing {1'b1, OP} field.
module mtm_alu_crc4_step
    import mtm_alu_pkg::*;
#(
    parameter logic [3:0] POLY = CRC4_POLY
) (
    input  logic [3:0] crc_in,
    input  logic [7:0] data,
    input  logic       bits8,
    output logic [3:0] crc_out
);

    logic [7:0] bits;

    // In nibble mode the payload is moved to the top so both modes consume from bit 7 down
    assign bits = bits8 ? data : {data[3:0], 4'h0};

    always_comb begin
        logic [3:0] crc;
        logic       fb;
        crc = crc_in;
        fb  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bits8 || (i < 4)) begin
                fb  = crc[3] ^ bits[7-i];
                crc = {crc[2:0], 1'b0} ^ (fb ? POLY : 4'h0);
            end
        end
        crc_out = crc;
    end

endmodule

// File: rtl/mtm_alu_frame_ctrl.sv
// Assembles deserializer packets into {B, A, OP} frames, validates length, CRC
// and opcode, and presents the result to the ALU core with a valid/ready handshake.
module mtm_alu_frame_ctrl
    import mtm_alu_pkg::*;
#(
    parameter int         DATA_PKTS = 8,
    parameter logic [3:0] CRC_POLY  = CRC4_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  packet,
    input  logic        data_valid,
    input  logic        core_ready,
    output logic        frame_valid,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic [2:0]  err_out,
    output logic        pkt_drop
);

    localparam logic [3:0] PKTS4 = 4'(DATA_PKTS);

    frame_state_t state_reg;
    logic [63:0]  shift_reg;
    logic [3:0]   cnt_reg;
    logic [3:0]   crc_reg;
    logic [3:0]   crc_rx_reg;
    logic [2:0]   op_reg;

    logic         is_cmd;
    logic [7:0]   crc_data;
    logic [3:0]   crc_next;
    logic [2:0]   err_next;
    logic         unused_stop;

    assign unused_stop = packet[0];
    assign is_cmd      = packet[9];
    // A command packet only contributes {1'b1, OP} to the CRC stream
    assign crc_data    = is_cmd ? {4'h0, 1'b1, packet[7:5]} : packet[8:1];

    mtm_alu_crc4_step #(
        .POLY    (CRC_POLY)
    ) u_crc_step (
        .crc_in  (crc_reg),
        .data    (crc_data),
        .bits8   (~is_cmd),
        .crc_out (crc_next)
    );

    always_comb begin
        err_next = 3'b000;
        if (cnt_reg != PKTS4) begin
            err_next[ERR_DATA_BIT] = 1'b1;
        end else if (crc_reg != crc_rx_reg) begin
            err_next[ERR_CRC_BIT] = 1'b1;
        end else if (!op_is_legal(op_reg)) begin
            err_next[ERR_OP_BIT] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_COLLECT;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            crc_reg     <= '0;
            crc_rx_reg  <= '0;
            op_reg      <= '0;
            frame_valid <= 1'b0;
            a_out       <= '0;
            b_out       <= '0;
            op_out      <= '0;
            err_out     <= '0;
            pkt_drop    <= 1'b0;
        end else begin
            pkt_drop <= 1'b0;
            case (state_reg)
                ST_COLLECT: begin
                    if (data_valid) begin
                        crc_reg <= crc_next;
                        if (!is_cmd) begin
                            shift_reg <= {shift_reg[55:0], packet[8:1]};
                            if (cnt_reg != 4'hF) begin
                                cnt_reg <= cnt_reg + 4'd1;
                            end
                        end else begin
                            op_reg     <= packet[7:5];
                            crc_rx_reg <= packet[4:1];
                            state_reg  <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    pkt_drop    <= data_valid;
                    b_out       <= shift_reg[63:32];
                    a_out       <= shift_reg[31:0];
                    op_out      <= op_reg;
                    err_out     <= err_next;
                    frame_valid <= 1'b1;
                    state_reg   <= ST_HOLD;
                end
                ST_HOLD: begin
                    pkt_drop <= data_valid;
                    if (core_ready) begin
                        frame_valid <= 1'b0;
                        shift_reg   <= '0;
                        cnt_reg     <= '0;
                        crc_reg     <= '0;
                        state_reg   <= ST_COLLECT;
                    end
                end
                default: state_reg <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_frame_ctrl.sv
// Directed and randomized frames for mtm_alu_frame_ctrl, checked against a
// reference built from byte lists and a long-division CRC.
module tb_mtm_alu_frame_ctrl;

    localparam int GAP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  packet = '0;
    logic        data_valid = 1'b0;
    logic        core_ready = 1'b0;
    logic        frame_valid;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic [2:0]  err_out;
    logic        pkt_drop;

    int total = 0;
    int bad   = 0;

    mtm_alu_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .packet      (packet),
        .data_valid  (data_valid),
        .core_ready  (core_ready),
        .frame_valid (frame_valid),
        .a_out       (a_out),
        .b_out       (b_out),
        .op_out      (op_out),
        .err_out     (err_out),
        .pkt_drop    (pkt_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of polynomial division of {stream, 0000} by x^4+x+1
    function automatic logic [3:0] ref_crc(input logic [63:0] ba, input logic [2:0] op);
        logic [71:0] m;
        m = {ba, 1'b1, op, 4'h0};
        for (int i = 71; i >= 4; i--) begin
            if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
        end
        return m[3:0];
    endfunction

    function automatic logic legal_op(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
    endfunction

    task automatic send_data(input logic [7:0] pl);
        @(negedge clk);
        packet = {1'b0, pl, 1'b1};
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        packet = 10'($urandom);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".fv"}, 64'(frame_valid), 64'd0);
        chk({tag, ".ba"}, {b_out, a_out}, 64'd0);
        chk({tag, ".op_err_drop"}, 64'({op_out, err_out, pkt_drop}), 64'd0);
    endtask

    task automatic run_frame(input string tag, input logic [63:0] ba, input logic [2:0] op,
                             input int n, input bit flip, input int hold,
                             input bit drop, input bit no_hs);
        logic [7:0] q[$];
        logic [3:0] crc;
        logic [63:0] eba;
        logic [2:0] eerr;
        int m;
        for (int i = 0; i < n - 8; i++) q.push_back(8'($urandom));
        for (int i = (n < 8) ? 8 - n : 0; i < 8; i++) q.push_back(ba[63-8*i -: 8]);
        crc = ref_crc(ba, op) ^ {3'b000, flip};
        foreach (q[i]) send_data(q[i]);

        // Expected operands: the last eight bytes sent, right-aligned, zero-padded
        eba = '0;
        m = (q.size() < 8) ? q.size() : 8;
        for (int k = 0; k < m; k++) eba[8*k +: 8] = q[q.size()-1-k];
        if (n != 8)              eerr = 3'b100;
        else if (flip)           eerr = 3'b010;
        else if (!legal_op(op))  eerr = 3'b001;
        else                     eerr = 3'b000;

        @(negedge clk);
        packet = {1'b1, 1'b0, op, crc, 1'b1};
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk({tag, ".fv_n1"}, 64'(frame_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".fv_n2"}, 64'(frame_valid), 64'd1);
        chk({tag, ".ba"}, {b_out, a_out}, eba);
        chk({tag, ".op"}, 64'(op_out), 64'(op));
        chk({tag, ".err"}, 64'(err_out), 64'(eerr));
        $display("frame %s: n=%0d op=%0b ba=%h err=%0b", tag, n, op, {b_out, a_out}, err_out);

        if (drop) begin
            packet = {1'b0, 8'hA5, 1'b1};
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            chk({tag, ".drop_pulse"}, 64'(pkt_drop), 64'd1);
            @(negedge clk);
            chk({tag, ".drop_end"}, 64'(pkt_drop), 64'd0);
            chk({tag, ".drop_ba"}, {b_out, a_out}, eba);
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk({tag, ".hold_fv"}, 64'(frame_valid), 64'd1);
            chk({tag, ".hold_ba"}, {b_out, a_out}, eba);
            chk({tag, ".hold_op_err"}, 64'({op_out, err_out}), 64'({op, eerr}));
        end
        if (!no_hs) begin
            core_ready = 1'b1;
            @(negedge clk);
            core_ready = 1'b0;
            chk({tag, ".hs_fv"}, 64'(frame_valid), 64'd0);
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero(tag);
        $display("reset %s applied", tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic seen_fv;
        logic [63:0] rba;
        logic [2:0] rop;
        int rn;

        #1 check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Idle with core_ready asserted: nothing must appear
        core_ready = 1'b1;
        seen_fv = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (frame_valid) seen_fv = 1'b1;
        end
        core_ready = 1'b0;
        chk("idle.fv_seen", 64'(seen_fv), 64'd0);
        check_zero("idle");

        run_frame("add_good", {32'h2, 32'h1}, 3'b100, 8, 1'b0, 5, 1'b0, 1'b0);
        run_frame("crc_flip", {32'h2, 32'h1}, 3'b100, 8, 1'b1, 0, 1'b0, 1'b0);
        run_frame("bad_op",   {32'h2, 32'h1}, 3'b111, 8, 1'b0, 0, 1'b0, 1'b0);
        run_frame("seven",    64'h1122334455667788, 3'b000, 7, 1'b0, 0, 1'b0, 1'b0);
        run_frame("nine",     64'h99AABBCCDDEEFF00, 3'b001, 9, 1'b1, 0, 1'b0, 1'b0);
        run_frame("zero",     64'h0, 3'b101, 0, 1'b0, 1, 1'b0, 1'b0);
        run_frame("hold_drop", 64'hDEADBEEF01234567, 3'b101, 8, 1'b0, 2, 1'b1, 1'b0);
        run_frame("after_drop", 64'hCAFEF00D0BADBEEF, 3'b000, 8, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) send_data(8'(8'hF0 + i));
        async_reset("mid_collect");
        run_frame("post_rst1", 64'h0102030405060708, 3'b001, 8, 1'b0, 0, 1'b0, 1'b0);

        run_frame("in_hold", 64'h5555AAAA3333CCCC, 3'b100, 8, 1'b0, 0, 1'b0, 1'b1);
        async_reset("hold");
        run_frame("post_rst2", 64'h0F0E0D0C0B0A0908, 3'b101, 8, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rba = {$urandom, $urandom};
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       rn = 7;
                1:       rn = 9;
                default: rn = 8;
            endcase
            run_frame($sformatf("rnd%0d", i), rba, rop, rn, ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
